stc0_bfsched: RTL and testbench
===============================

# stc0_bfsched

Sequencer for the stc0 butterfly pipeline. On a host command it walks the butterfly control daisy chain, loads each multiplier-bearing stage's twiddle RAM from a streaming source, then programs every stage's run-mode control word (scaling schedule), signalling completion to the host. It sits between the host register block and butterfly stage 0, driving the chain's CtrlAddr/CtrlWord/CtrlValid and the B ingress lanes during loads.

## Interface
- NUM_POINTS_LOG2, 10, number of butterfly stages (stage index s = 0..NUM_POINTS_LOG2-1)
- DATA_WIDTH, 17, butterfly data lane width
- TW_WIDTH, 16, twiddle component width
- GAP_CYCLES, NUM_POINTS_LOG2+2, idle cycles after each control burst before data or Done

Ports:
- Clk  in  1  clock
- Rst  in  1  reset; asynchronous, active-high
- Start  in  1  command strobe, sampled in IDLE only
- Mode  in  1  1 = load twiddles then configure; 0 = configure only
- Abort  in  1  return to IDLE at next edge
- ScaleSched  in  2*NUM_POINTS_LOG2  2-bit scaling field per stage, stage s at [2s+1:2s]
- TwData  in  2*TW_WIDTH  twiddle word {twR, twI}
- TwValid  in  1  TwData valid
- TwReady  out  1  sequencer accepts TwData
- CtrlAddr  out  4  target stage
- CtrlWord  out  `CTRLWRD_SZ  control word
- CtrlValid  out  1  control strobe
- Ar, Ai  out  DATA_WIDTH  held 0
- Br, Bi  out  DATA_WIDTH  sign-extended twR, twI
- IngressValid  out  1  data strobe to stage 0
- Busy  out  1  command in progress
- Done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, TW_CFG, TW_GAP, TW_STREAM, RUN_CFG, RUN_GAP, DONE.
- IDLE: Start=1 → TW_CFG with s=0 if Mode=1, else RUN_CFG with s=0. Busy rises on the following edge.
- Load stages: s = 0..NUM_POINTS_LOG2-3 only (last two stages have no multipliers). Depth(s) = 2^(NUM_POINTS_LOG2-1-s).
- TW_CFG: one cycle, CtrlValid=1, CtrlAddr=s, CtrlWord = scaling bits[1:0] from ScaleSched, `RB_BFCTRL_TWWR set, all other bits 0 → TW_GAP.
- TW_GAP: count GAP_CYCLES → TW_STREAM, word counter cleared.
- TW_STREAM: TwReady=1; each cycle with TwValid=1 drives Br/Bi from TwData and IngressValid=1, counter increments. TwValid=0 → IngressValid=0 (stall, no timeout). On the Depth(s)-th word: s<NUM_POINTS_LOG2-3 → s+1, TW_CFG; else s=0, RUN_CFG.
- RUN_CFG: NUM_POINTS_LOG2 consecutive cycles, one CtrlValid per cycle, CtrlAddr=s ascending 0..NUM_POINTS_LOG2-1, CtrlWord = scaling field only (TWWR, TWRD, BYPASS, TWMUXCTRL all 0) → RUN_GAP.
- RUN_GAP: GAP_CYCLES → DONE. DONE: Done=1 one cycle, Busy=0 same cycle → IDLE.
- Abort (any non-IDLE state): next edge IDLE, all strobes 0, Busy 0, no Done. Abort has priority over Start when both high in IDLE (Start ignored).
- Start while Busy: ignored. ScaleSched sampled when each control word is emitted (host holds stable while Busy).

## Timing
- Reset values: all outputs 0 (TwReady 0, Busy 0, Done 0, CtrlAddr 0, CtrlWord 0, Br/Bi 0); state IDLE, counters 0. Reset mid-command abandons it; no Done.
- All outputs registered; TwReady is a registered state decode, so a TwData handshake is the cycle TwValid & TwReady, and IngressValid/Br/Bi appear the next cycle.
- Configure-only latency Start→Done: 1 + NUM_POINTS_LOG2 + GAP_CYCLES + 1 cycles.
- CtrlValid and IngressValid are never high in the same cycle; at least GAP_CYCLES separate a control word from the next data word.
- Exactly Depth(s) IngressValid pulses per load stage; a TwReady handshake is never dropped.

## Structure
- Control bit positions (`RB_BFCTRL_*`) and `CTRLWRD_SZ come from stc0_addrMap.vh; state encoding is a local set of localparams.
- Reset synchronization uses the existing rstSync instance, as in the butterfly.
- No sub-module; one FSM plus stage, word and gap counters (word counter NUM_POINTS_LOG2 bits).

## Test plan
- Mode=0, NUM_POINTS_LOG2=4, ScaleSched=8'b10_01_00_11 → 4 CtrlValid pulses, addrs 0,1,2,3, CtrlWord[1:0]=3,0,1,2; Done at cycle 1+4+6+1 after Start.
- Mode=1, NUM_POINTS_LOG2=4, TwValid held 1 → TW_CFG addr 0 (TWWR=1), 8 IngressValid, TW_CFG addr 1, 4 IngressValid, then 4 run words with TWWR=0, Done.
- Load with TwValid toggling 1/0 → IngressValid follows, total counts 8 and 4, TwData 0x4567_2345 gives Br=0x04567, Bi=0x02345.
- Negative twR 0x8000 → Br = 17'h18000 (sign-extended).
- Abort during TW_STREAM word 3 → next cycle IDLE, Busy 0, no further strobes, no Done; following Start runs a full clean sequence.
- Start pulsed while Busy, and Rst asserted mid-RUN_CFG → Start ignored; Rst clears all outputs to 0 immediately.

Source files
------------

// File: rtl/stc0_bfsched_pkg.sv
// Butterfly control-word layout shared by the stc0 sequencer and its bench.
// Bit positions mirror the stc0 address map; unlisted bits are reserved and driven 0.
package stc0_bfsched_pkg;

    localparam int CTRLWRD_SZ          = 8;
    localparam int RB_BFCTRL_SCALE     = 0;
    localparam int RB_BFCTRL_TWWR      = 2;
    localparam int RB_BFCTRL_TWRD      = 3;
    localparam int RB_BFCTRL_BYPASS    = 4;
    localparam int RB_BFCTRL_TWMUXCTRL = 5;

    typedef logic [CTRLWRD_SZ-1:0] ctrl_word_t;

    function automatic ctrl_word_t make_ctrl(input logic [1:0] scale, input logic twwr);
        ctrl_word_t w;
        w = '0;
        w[RB_BFCTRL_SCALE +: 2] = scale;
        w[RB_BFCTRL_TWWR]       = twwr;
        return w;
    endfunction

endpackage

// File: rtl/stc0_bfsched.sv
// Butterfly pipeline sequencer: optional twiddle-RAM load per multiplier stage, then
// run-mode control words for every stage; all outputs registered one cycle after state.
module stc0_bfsched
    import stc0_bfsched_pkg::*;
#(
    parameter int NUM_POINTS_LOG2 = 10,
    parameter int DATA_WIDTH      = 17,
    parameter int TW_WIDTH        = 16,
    parameter int GAP_CYCLES      = NUM_POINTS_LOG2 + 2
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         Start,
    input  logic                         Mode,
    input  logic                         Abort,
    input  logic [2*NUM_POINTS_LOG2-1:0] ScaleSched,
    input  logic [2*TW_WIDTH-1:0]        TwData,
    input  logic                         TwValid,
    output logic                         TwReady,
    output logic [3:0]                   CtrlAddr,
    output logic [CTRLWRD_SZ-1:0]        CtrlWord,
    output logic                         CtrlValid,
    output logic [DATA_WIDTH-1:0]        Ar,
    output logic [DATA_WIDTH-1:0]        Ai,
    output logic [DATA_WIDTH-1:0]        Br,
    output logic [DATA_WIDTH-1:0]        Bi,
    output logic                         IngressValid,
    output logic                         Busy,
    output logic                         Done
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_TW_CFG    = 3'd1;
    localparam logic [2:0] ST_TW_GAP    = 3'd2;
    localparam logic [2:0] ST_TW_STREAM = 3'd3;
    localparam logic [2:0] ST_RUN_CFG   = 3'd4;
    localparam logic [2:0] ST_RUN_GAP   = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [3:0]    LAST_LOAD_STAGE = 4'(NUM_POINTS_LOG2 - 3);
    localparam logic [3:0]    LAST_RUN_STAGE  = 4'(NUM_POINTS_LOG2 - 1);
    localparam logic [GW-1:0] GAP_LAST        = GW'(GAP_CYCLES - 1);

    logic [2:0]                   state;
    logic [3:0]                   stage;
    logic [NUM_POINTS_LOG2-1:0]   word_cnt;
    logic [GW-1:0]                gap_cnt;
    logic [2*NUM_POINTS_LOG2-1:0] sched_shift;
    logic [1:0]                   scale;
    logic [NUM_POINTS_LOG2-1:0]   last_word;
    logic                         tw_hs;
    logic                         gap_end;

    assign sched_shift = ScaleSched >> {stage, 1'b0};
    assign scale       = sched_shift[1:0];
    // Depth(s) - 1 = 2^(N-1-s) - 1, i.e. an all-ones word shifted right by s+1.
    assign last_word   = {NUM_POINTS_LOG2{1'b1}} >> (stage + 4'd1);
    assign tw_hs       = TwValid && TwReady;
    assign gap_end     = (gap_cnt == GAP_LAST);

    assign Ar = '0;
    assign Ai = '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= ST_IDLE;
            stage        <= '0;
            word_cnt     <= '0;
            gap_cnt      <= '0;
            TwReady      <= 1'b0;
            CtrlAddr     <= '0;
            CtrlWord     <= '0;
            CtrlValid    <= 1'b0;
            Br           <= '0;
            Bi           <= '0;
            IngressValid <= 1'b0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
        end else begin
            CtrlValid    <= 1'b0;
            CtrlAddr     <= '0;
            CtrlWord     <= '0;
            IngressValid <= 1'b0;
            Done         <= 1'b0;
            TwReady      <= 1'b0;
            Busy         <= (state != ST_IDLE) && (state != ST_DONE);

            if (Abort) begin
                state    <= ST_IDLE;
                stage    <= '0;
                word_cnt <= '0;
                gap_cnt  <= '0;
                Busy     <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (Start) begin
                            stage <= '0;
                            state <= Mode ? ST_TW_CFG : ST_RUN_CFG;
                        end
                    end
                    ST_TW_CFG: begin
                        CtrlValid <= 1'b1;
                        CtrlAddr  <= stage;
                        CtrlWord  <= make_ctrl(scale, 1'b1);
                        gap_cnt   <= '0;
                        state     <= ST_TW_GAP;
                    end
                    ST_TW_GAP: begin
                        if (gap_end) begin
                            gap_cnt  <= '0;
                            word_cnt <= '0;
                            TwReady  <= 1'b1;
                            state    <= ST_TW_STREAM;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    ST_TW_STREAM: begin
                        TwReady <= 1'b1;
                        if (tw_hs) begin
                            IngressValid <= 1'b1;
                            Br <= {{(DATA_WIDTH-TW_WIDTH){TwData[2*TW_WIDTH-1]}},
                                   TwData[2*TW_WIDTH-1:TW_WIDTH]};
                            Bi <= {{(DATA_WIDTH-TW_WIDTH){TwData[TW_WIDTH-1]}},
                                   TwData[TW_WIDTH-1:0]};
                            if (word_cnt == last_word) begin
                                // Ready drops with the final word so no extra handshake is offered.
                                TwReady  <= 1'b0;
                                word_cnt <= '0;
                                if (stage == LAST_LOAD_STAGE) begin
                                    stage <= '0;
                                    state <= ST_RUN_CFG;
                                end else begin
                                    stage <= stage + 4'd1;
                                    state <= ST_TW_CFG;
                                end
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                            end
                        end
                    end
                    ST_RUN_CFG: begin
                        CtrlValid <= 1'b1;
                        CtrlAddr  <= stage;
                        CtrlWord  <= make_ctrl(scale, 1'b0);
                        if (stage == LAST_RUN_STAGE) begin
                            stage   <= '0;
                            gap_cnt <= '0;
                            state   <= ST_RUN_GAP;
                        end else begin
                            stage <= stage + 4'd1;
                        end
                    end
                    ST_RUN_GAP: begin
                        if (gap_end) begin
                            gap_cnt <= '0;
                            state   <= ST_DONE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        Done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stc0_bfsched.sv
// Bench for stc0_bfsched at NUM_POINTS_LOG2=4: per-cycle expected tables built from the
// sequencing rules, plus hand-written abort and mid-command reset sequences.
module tb_stc0_bfsched;
    import stc0_bfsched_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 17;
    localparam int TW   = 16;
    localparam int GAP  = N + 2;
    localparam int MAXC = 512;

    logic            clk = 1'b0;
    logic            rst;
    logic            start, mode, abort, tw_valid;
    logic [2*N-1:0]  sched;
    logic [2*TW-1:0] tw_data;
    logic            tw_ready, ctrl_valid, ingress_valid, busy, done;
    logic [3:0]      ctrl_addr;
    logic [CTRLWRD_SZ-1:0] ctrl_word;
    logic [DW-1:0]   ar, ai, br, bi;

    always #5 clk = ~clk;

    stc0_bfsched #(.NUM_POINTS_LOG2(N), .DATA_WIDTH(DW), .TW_WIDTH(TW)) dut (
        .Clk(clk), .Rst(rst), .Start(start), .Mode(mode), .Abort(abort),
        .ScaleSched(sched), .TwData(tw_data), .TwValid(tw_valid), .TwReady(tw_ready),
        .CtrlAddr(ctrl_addr), .CtrlWord(ctrl_word), .CtrlValid(ctrl_valid),
        .Ar(ar), .Ai(ai), .Br(br), .Bi(bi), .IngressValid(ingress_valid),
        .Busy(busy), .Done(done)
    );

    typedef struct {
        logic            start;
        logic            mode;
        logic            tw_valid;
        logic [2*TW-1:0] tw_data;
        logic            cv, iv, dn, bsy, rdy;
        logic [3:0]      ca;
        logic [CTRLWRD_SZ-1:0] cw;
        logic [DW-1:0]   br, bi;
    } vec_t;

    vec_t vec [MAXC];
    int   vlen;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [DW-1:0] sext(input logic [TW-1:0] x);
        return {{(DW-TW){x[TW-1]}}, x};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic put_ctrl(input int t, input int s, input bit twwr);
        int f;
        f = (int'(sched) >> (2 * s)) & 3;
        vec[t].cv = 1'b1;
        vec[t].ca = 4'(s);
        vec[t].cw = CTRLWRD_SZ'(f + (twwr ? (1 << RB_BFCTRL_TWWR) : 0));
    endtask

    // Cycle 0 is the Start cycle; control words surface the cycle after their state,
    // data the cycle after its handshake, Done GAP+1 cycles after the last run word.
    task automatic build(input logic m, input int tvkind, input logic [31:0] fixed_td, input bit noise);
        int o, c, cnt, h, dn;
        for (int k = 0; k < MAXC; k++) begin
            vec[k] = '{default: '0};
            vec[k].mode = m;
            case (tvkind)
                0:       vec[k].tw_valid = 1'b1;
                1:       vec[k].tw_valid = (k % 2) == 0;
                default: vec[k].tw_valid = (k > 200) || (($urandom % 2) != 0);
            endcase
            vec[k].tw_data = (fixed_td != 0) ? fixed_td : $urandom;
        end
        vec[0].start = 1'b1;
        o = 2;
        if (m) begin
            for (int s = 0; s <= N - 3; s++) begin
                put_ctrl(o, s, 1'b1);
                c = o + GAP;
                cnt = 0;
                h = c;
                while (cnt < (1 << (N - 1 - s))) begin
                    vec[c].rdy = 1'b1;
                    if (vec[c].tw_valid) begin
                        vec[c+1].iv = 1'b1;
                        vec[c+1].br = sext(vec[c].tw_data[2*TW-1:TW]);
                        vec[c+1].bi = sext(vec[c].tw_data[TW-1:0]);
                        cnt++;
                        h = c;
                    end
                    c++;
                end
                o = h + 2;
            end
        end
        for (int s = 0; s < N; s++) put_ctrl(o + s, s, 1'b0);
        dn = o + N - 1 + GAP + 1;
        vec[dn].dn = 1'b1;
        for (int k = 2; k < dn; k++) vec[k].bsy = 1'b1;
        if (noise) begin
            for (int k = 1; k < dn; k++) if ($urandom_range(0, 4) == 0) vec[k].start = 1'b1;
        end
        vlen = dn + 4;
    endtask

    task automatic apply(input string tag, output int done_cyc, output int n_iv,
                         output logic [DW-1:0] last_br, output logic [DW-1:0] last_bi);
        bit ok;
        done_cyc = -1;
        n_iv = 0;
        last_br = '0;
        last_bi = '0;
        for (int c = 0; c < vlen; c++) begin
            start    = vec[c].start;
            mode     = vec[c].mode;
            tw_valid = vec[c].tw_valid;
            tw_data  = vec[c].tw_data;
            @(negedge clk);
            ok = (ctrl_valid === vec[c].cv) && (ingress_valid === vec[c].iv) &&
                 (done === vec[c].dn) && (busy === vec[c].bsy) && (tw_ready === vec[c].rdy) &&
                 (ar === '0) && (ai === '0) &&
                 (!vec[c].cv || (ctrl_addr === vec[c].ca && ctrl_word === vec[c].cw)) &&
                 (!vec[c].iv || (br === vec[c].br && bi === vec[c].bi));
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s cyc%0d: got cv=%0b ca=%0d cw=%0h iv=%0b br=%0h bi=%0h dn=%0b bsy=%0b rdy=%0b; want cv=%0b ca=%0d cw=%0h iv=%0b br=%0h bi=%0h dn=%0b bsy=%0b rdy=%0b",
                         tag, c, ctrl_valid, ctrl_addr, ctrl_word, ingress_valid, br, bi, done, busy, tw_ready,
                         vec[c].cv, vec[c].ca, vec[c].cw, vec[c].iv, vec[c].br, vec[c].bi,
                         vec[c].dn, vec[c].bsy, vec[c].rdy);
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (ingress_valid === 1'b1) begin
                n_iv++;
                last_br = br;
                last_bi = bi;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        tw_valid = 1'b0;
    endtask

    task automatic check_quiet(input string name, input bit full);
        check(name, {ctrl_valid, ingress_valid, done, busy, tw_ready}, 64'd0);
        if (full) check({name, "_data"}, {ctrl_addr, ctrl_word, br, bi, ar, ai}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcyc, niv, n, cyc;
        logic [DW-1:0] lbr, lbi;
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; abort = 1'b0; tw_valid = 1'b0;
        tw_data = '0; sched = '0;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_held", 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("reset_release", 1'b1);

        sched = 8'b10_01_00_11;
        build(1'b0, 0, 32'h0, 1'b0);
        apply("cfg_only", dcyc, niv, lbr, lbi);
        check("cfg_only_latency", 64'(dcyc), 64'd12);

        sched = 8'($urandom);
        build(1'b1, 0, 32'h0, 1'b0);
        apply("load_held", dcyc, niv, lbr, lbi);
        check("load_held_words", 64'(niv), 64'd12);

        build(1'b1, 1, 32'h4567_2345, 1'b0);
        apply("load_toggle", dcyc, niv, lbr, lbi);
        check("load_toggle_words", 64'(niv), 64'd12);
        check("load_toggle_br", 64'(lbr), 64'h04567);
        check("load_toggle_bi", 64'(lbi), 64'h02345);

        build(1'b1, 2, 32'h8000_FFFF, 1'b0);
        apply("load_neg", dcyc, niv, lbr, lbi);
        check("load_neg_br", 64'(lbr), 64'h18000);
        check("load_neg_bi", 64'(lbi), 64'h1FFFF);

        for (int r = 0; r < 6; r++) begin
            sched = 8'($urandom);
            build(1'($urandom_range(0, 1)), 2, 32'h0, 1'b1);
            apply($sformatf("rand%0d", r), dcyc, niv, lbr, lbi);
        end

        // Abort lands on the cycle of the third stream handshake.
        sched = 8'($urandom);
        mode = 1'b1; tw_valid = 1'b1; tw_data = $urandom; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 100) begin
            @(negedge clk);
            if (ingress_valid === 1'b1) n++;
            if (n == 2) abort = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("abort_reached_word3", 64'(n), 64'd2);
        abort = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", k), {ctrl_valid, ingress_valid, done, busy, tw_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        tw_valid = 1'b0;
        sched = 8'($urandom);
        build(1'b1, 2, 32'h0, 1'b0);
        apply("after_abort", dcyc, niv, lbr, lbi);

        // Reset during the run-configuration burst.
        sched = 8'($urandom);
        mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (ctrl_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_mid_cfg_seen", 64'(ctrl_valid), 64'd1);
        @(posedge clk);
        #2;
        start = 1'b1;
        rst = 1'b1;
        #1;
        check_quiet("rst_mid_cfg", 1'b1);
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d", k), {ctrl_valid, ingress_valid, done, busy, tw_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        sched = 8'($urandom);
        build(1'b0, 0, 32'h0, 1'b1);
        apply("after_rst", dcyc, niv, lbr, lbi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
